// File: rtl/cache_arbiter.sv
// Round-robin 2:1 arbiter sharing one line-granular memory port
// between the instruction-side and data-side L1 caches.
module cache_arbiter #(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_read,
  input  logic [s_addr-1:0] inst_address,
  output logic              inst_resp,
  output logic [s_line-1:0] inst_rdata,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [s_addr-1:0] data_address,
  input  logic [s_line-1:0] data_wdata,
  output logic              data_resp,
  output logic [s_line-1:0] data_rdata,
  output logic              downstream_read,
  output logic              downstream_write,
  output logic [s_addr-1:0] downstream_address,
  output logic [s_line-1:0] downstream_wdata,
  input  logic              downstream_resp,
  input  logic [s_line-1:0] downstream_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last_grant;
  logic   w_last_grant_nxt;
  logic   w_inst_pend;
  logic   w_data_pend;

  assign w_inst_pend = inst_read;
  assign w_data_pend = data_read | data_write;

  assign inst_rdata = downstream_rdata;
  assign data_rdata = downstream_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_last_grant_nxt   = r_last_grant;
    downstream_read    = 1'b0;
    downstream_write   = 1'b0;
    downstream_address = data_address;
    downstream_wdata   = data_wdata;
    inst_resp          = 1'b0;
    data_resp          = 1'b0;
    unique case (r_state)
      IDLE: begin
        // On a tie the side not served last wins
        if (w_inst_pend && w_data_pend) begin
          w_state_nxt = r_last_grant ? GRANT_I : GRANT_D;
        end else if (w_inst_pend) begin
          w_state_nxt = GRANT_I;
        end else if (w_data_pend) begin
          w_state_nxt = GRANT_D;
        end
        if (w_state_nxt == GRANT_I) begin
          w_last_grant_nxt = 1'b0;
        end else if (w_state_nxt == GRANT_D) begin
          w_last_grant_nxt = 1'b1;
        end
      end
      GRANT_I: begin
        downstream_read    = inst_read;
        downstream_address = inst_address;
        if (downstream_resp) begin
          inst_resp   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      GRANT_D: begin
        downstream_read  = data_read;
        downstream_write = data_write;
        if (downstream_resp) begin
          data_resp   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed and randomized bench for cache_arbiter with a
// rule-level grant model and bench-side downstream memory.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_read;
  logic [AW-1:0] inst_address;
  logic          inst_resp;
  logic [LW-1:0] inst_rdata;
  logic          data_read;
  logic          data_write;
  logic [AW-1:0] data_address;
  logic [LW-1:0] data_wdata;
  logic          data_resp;
  logic [LW-1:0] data_rdata;
  logic          ds_read;
  logic          ds_write;
  logic [AW-1:0] ds_address;
  logic [LW-1:0] ds_wdata;
  logic          ds_resp;
  logic [LW-1:0] ds_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  bit m_last = 1'b0;

  cache_arbiter #(.s_line(LW), .s_addr(AW)) dut (
    .clk                (clk),
    .rst                (rst),
    .inst_read          (inst_read),
    .inst_address       (inst_address),
    .inst_resp          (inst_resp),
    .inst_rdata         (inst_rdata),
    .data_read          (data_read),
    .data_write         (data_write),
    .data_address       (data_address),
    .data_wdata         (data_wdata),
    .data_resp          (data_resp),
    .data_rdata         (data_rdata),
    .downstream_read    (ds_read),
    .downstream_write   (ds_write),
    .downstream_address (ds_address),
    .downstream_wdata   (ds_wdata),
    .downstream_resp    (ds_resp),
    .downstream_rdata   (ds_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [LW-1:0] obs,
                     input logic [LW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Rule: a lone requester wins; a tie goes away from the last winner
  function automatic bit pick(bit ip, bit dp, bit last);
    if (ip && dp) return !last;
    return dp;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int w = 0; w < LW / 32; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  // Called at posedge+1 of an IDLE cycle with requests applied.
  task automatic serve(input int lat, input logic [LW-1:0] rd);
    bit side;
    side = pick(inst_read, data_read | data_write, m_last);
    @(negedge clk);
    chk("idle_rd", ds_read, 1'b0);
    chk("idle_wr", ds_write, 1'b0);
    tick();
    m_last = side;
    for (int c = 1; c <= lat; c++) begin
      if (c == lat) begin
        ds_resp  = 1'b1;
        ds_rdata = rd;
      end else begin
        ds_rdata = rnd_line();
      end
      @(negedge clk);
      chk("ds_read", ds_read, side ? data_read : inst_read);
      chk("ds_write", ds_write, side ? data_write : 1'b0);
      chk("ds_addr", ds_address, side ? data_address : inst_address);
      if (side) chk("ds_wdata", ds_wdata, data_wdata);
      chk("inst_resp", inst_resp, (c == lat) && !side);
      chk("data_resp", data_resp, (c == lat) && side);
      if (c == lat) chk("rdata", side ? data_rdata : inst_rdata, rd);
      tick();
    end
    ds_resp = 1'b0;
    if (side) begin
      data_read  = 1'b0;
      data_write = 1'b0;
    end else begin
      inst_read = 1'b0;
    end
  endtask

  task automatic req_inst(input logic [AW-1:0] a);
    inst_read    = 1'b1;
    inst_address = a;
  endtask

  task automatic req_data(input bit wr, input logic [AW-1:0] a);
    data_read    = !wr;
    data_write   = wr;
    data_address = a;
    data_wdata   = rnd_line();
  endtask

  initial begin
    rst          = 1'b1;
    inst_read    = 1'b0;
    inst_address = '0;
    data_read    = 1'b0;
    data_write   = 1'b0;
    data_address = '0;
    data_wdata   = '0;
    ds_resp      = 1'b0;
    ds_rdata     = '0;
    #2;
    chk("rst_rd", ds_read, 1'b0);
    chk("rst_wr", ds_write, 1'b0);
    chk("rst_iresp", inst_resp, 1'b0);
    chk("rst_dresp", data_resp, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Lone inst read, resp three cycles after the grant cycle
    req_inst(32'h0000_0060);
    serve(4, {32{8'hA5}});

    // Tie after reset: data wins, inst follows after one bubble
    req_inst(32'h0000_0100);
    req_data(1'b1, 32'h0000_0200);
    serve(2, rnd_line());
    serve(1, rnd_line());

    // Saturation: served side re-requests immediately
    req_inst(32'h0000_1000);
    req_data(1'b1, 32'h0000_2000);
    for (int t = 0; t < 8; t++) begin
      serve($urandom_range(1, 3), rnd_line());
      if (!inst_read) req_inst(32'h0000_1000 + AW'(t) * 32'h40);
      if (!(data_read | data_write))
        req_data(t[0], 32'h0000_2000 + AW'(t) * 32'h40);
    end
    serve(1, rnd_line());
    serve(1, rnd_line());

    // Spurious downstream_resp while idle
    ds_resp = 1'b1;
    @(negedge clk);
    chk("spur_iresp", inst_resp, 1'b0);
    chk("spur_dresp", data_resp, 1'b0);
    chk("spur_rd", ds_read, 1'b0);
    tick();
    ds_resp = 1'b0;
    @(negedge clk);
    chk("spur_idle_rd", ds_read, 1'b0);
    chk("spur_idle_wr", ds_write, 1'b0);
    tick();
    req_inst(32'h0000_3000);
    req_data(1'b0, 32'h0000_4000);
    serve(2, rnd_line());
    serve(2, rnd_line());

    // Reset while data write is granted
    req_data(1'b1, 32'h0000_5000);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("pre_rst_wr", ds_write, 1'b1);
    #1;
    rst     = 1'b1;
    ds_resp = 1'b1;
    #1;
    chk("mid_rst_wr", ds_write, 1'b0);
    chk("mid_rst_rd", ds_read, 1'b0);
    chk("mid_rst_dresp", data_resp, 1'b0);
    chk("mid_rst_iresp", inst_resp, 1'b0);
    data_write = 1'b0;
    ds_resp    = 1'b0;
    tick();
    rst    = 1'b0;
    m_last = 1'b0;
    req_inst(32'h0000_6000);
    req_data(1'b1, 32'h0000_7000);
    serve(1, rnd_line());
    serve(1, rnd_line());

    // Data read path
    req_data(1'b0, 32'h1234_5680);
    serve(3, {8{32'hDEAD_BEEF}});

    // Randomized mix with idle gaps and spurious responses
    for (int t = 0; t < 40; t++) begin
      if (!inst_read && $urandom_range(0, 1) == 1)
        req_inst({$urandom_range(0, 32'hFFFF), 5'b0, 11'b0});
      if (!(data_read | data_write) && $urandom_range(0, 1) == 1)
        req_data($urandom_range(0, 1) == 1,
                 {$urandom_range(0, 32'hFFFF), 5'b0, 11'b0});
      if (!inst_read && !(data_read | data_write)) begin
        ds_resp = $urandom_range(0, 1) == 1;
        @(negedge clk);
        chk("rnd_idle_iresp", inst_resp, 1'b0);
        chk("rnd_idle_dresp", data_resp, 1'b0);
        chk("rnd_idle_rd", ds_read, 1'b0);
        chk("rnd_idle_wr", ds_write, 1'b0);
        tick();
        ds_resp = 1'b0;
      end else begin
        serve($urandom_range(1, 4), rnd_line());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-to-one arbiter that shares a single downstream line-granular memory port between the instruction-side and data-side L1 caches. It sits between the two L1 `cache_core_pipelined` downstream interfaces and the shared L2/physical memory. It serialises their misses and write-backs with round-robin fairness and routes the response back to the requester that issued the transaction. The instruction port is read-only; the data port issues reads and write-backs.

## Interface
Parameters:
- `s_line`, 256, width in bits of one cache line on every data bus.
- `s_addr`, 32, address width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_read`  in  1  instruction-side read request; held until `inst_resp`.
- `inst_address`  in  s_addr  instruction-side line address; stable while request held.
- `inst_resp`  out  1  one-cycle completion pulse to the instruction side.
- `inst_rdata`  out  s_line  read line; valid only while `inst_resp`=1.
- `data_read`  in  1  data-side read request; held until `data_resp`.
- `data_write`  in  1  data-side write-back request; held until `data_resp`.
- `data_address`  in  s_addr  data-side line address.
- `data_wdata`  in  s_line  write-back line.
- `data_resp`  out  1  one-cycle completion pulse to the data side.
- `data_rdata`  out  s_line  read line; valid only while `data_resp`=1.
- `downstream_read`  out  1  read request to shared memory.
- `downstream_write`  out  1  write request to shared memory.
- `downstream_address`  out  s_addr  address to shared memory.
- `downstream_wdata`  out  s_line  write data to shared memory.
- `downstream_resp`  in  1  one-cycle completion pulse from shared memory.
- `downstream_rdata`  in  s_line  read line; valid with `downstream_resp`.

## Operation
- State machine: IDLE, GRANT_I, GRANT_D. A 1-bit `last_grant` register holds the requester most recently granted (0 = inst, 1 = data).
- Pending definitions: inst_pending = `inst_read`; data_pending = `data_read` | `data_write`.
- IDLE transitions:
  - Only inst pending: go to GRANT_I.
  - Only data pending: go to GRANT_D.
  - Both pending: grant the side opposite `last_grant`.
  - Neither pending: stay in IDLE.
  - On every grant, `last_grant` updates to the granted side.
- GRANT_I:
  - Drive `downstream_read`=`inst_read`, `downstream_write`=0, `downstream_address`=`inst_address`.
  - On `downstream_resp`: pulse `inst_resp`, drive `inst_rdata`=`downstream_rdata`, and return to IDLE.
- GRANT_D:
  - Drive `downstream_read`=`data_read`, `downstream_write`=`data_write`, `downstream_address`=`data_address`, `downstream_wdata`=`data_wdata`.
  - On `downstream_resp`: pulse `data_resp`, drive `data_rdata`=`downstream_rdata`, and return to IDLE.
- In IDLE, `downstream_read` and `downstream_write` are 0. `downstream_address` and `downstream_wdata` are don't-care; drive them from the data port.
- `downstream_resp` received in IDLE is ignored: no upstream resp is generated and no state change occurs.
- The `_resp` output of the non-granted side is always 0. Its `_rdata` is don't-care; drive `downstream_rdata` to both.
- A grant is released only by `downstream_resp`. If the granted requester drops its request early (protocol violation), the downstream request drops with it, and the arbiter stays in the GRANT state until `downstream_resp`.
- Simultaneous `data_read` and `data_write` is illegal. Both are passed through unchanged; the arbiter does not check for it.
- Reset (asynchronous): state is IDLE and `last_grant`=0, so the first tie goes to data. All `_resp`, `downstream_read` and `downstream_write` are 0 immediately on assertion, including mid-transaction.

## Timing
- State and `last_grant` are registered. Downstream request and control outputs are decoded combinationally from the registered state.
- Upstream resp and rdata are combinational from `downstream_resp` and `downstream_rdata`, with zero added latency.
- Sequence for one request:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: downstream request asserted.
  - Cycle k (k ≥ 1): `downstream_resp` arrives, and the upstream `_resp` is asserted in the same cycle.
  - Cycle k+1: IDLE.
- Back-to-back: a request waiting during cycle k is sampled in IDLE at cycle k+1 and driven downstream at cycle k+2. There is exactly one idle bubble between transactions.
- Requesters deassert in the cycle after their resp, so IDLE never sees a stale request.

## Test plan
- Reset then lone inst read: `inst_read`=1, `inst_address`=0x0000_0060; downstream responds 3 cycles after grant with rdata=0xA5..A5. Required: `downstream_read`=1 from cycle 1, `inst_resp`=1 in the resp cycle with `inst_rdata`=0xA5..A5, and `data_resp`=0 throughout.
- Tie after reset: both `inst_read` and `data_write` rise in the same cycle. Required: data is granted first (`downstream_write`=1, address and wdata from the data port). Inst is granted at resp+2 cycles.
- Round-robin under saturation: both sides re-request immediately after each resp for 8 transactions. Required: grant order D,I,D,I,D,I,D,I, with exactly one IDLE cycle between grants.
- Spurious `downstream_resp` in IDLE: the pulse is delivered with no requests pending. Required: no `inst_resp` or `data_resp` pulse, state stays IDLE, and `last_grant` is unchanged.
- Reset mid-transaction: assert `rst` while in GRANT_D before `downstream_resp`. Required: `downstream_write`=0 in the same cycle, state is IDLE after release, and the next tie grants data.
- Data read path: `data_read`=1 at 0x1234_5680; resp delivered with rdata=0xDEAD..BEEF. Required: `data_rdata`=0xDEAD..BEEF while `data_resp`=1, and `downstream_write`=0 throughout.
